// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element table for the RAM BIST controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_CMP,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      M0,
      M1,
      M2,
      M3,
      M4,
      M5
   } elem_t;

   // Per-element attributes, bit i describes element Mi.
   // Direction: M3..M5 walk the address space downwards.
   localparam logic [7:0] EL_DOWN    = 8'b0011_1000;
   // Expected read value is all-ones in M2 and M4, all-zeros elsewhere.
   localparam logic [7:0] EL_RD_ONES = 8'b0001_0100;
   // Write value is all-ones in M1 and M3, all-zeros elsewhere.
   localparam logic [7:0] EL_WR_ONES = 8'b0000_1010;
   // Elements that write: M0 (write only) and M1..M4 (read then write).
   localparam logic [7:0] EL_WRITES  = 8'b0001_1111;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march walk, with load-to-start and terminal flag.
// Latency: load/step take effect on the next clk edge; last is combinational on addr.
// Backpressure: none; the controller steps it only when it advances.
module ram_bist_addr_gen #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  load_down,
   input  logic                  step,
   input  logic                  down,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   localparam logic [ADDR_WIDTH-1:0] TOP = '1;
   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   // Load jumps to the first address of an element; step walks one address.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_down ? TOP : '0;
      end else if (step) begin
         addr <= down ? (addr - ONE) : (addr + ONE);
      end
   end

   // An element ends at N-1 going up and at 0 going down; no wrap is relied upon.
   assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/ram_bist.sv
// March C- BIST controller driving a single-port RAM; reports pass or first failure.
// Latency: busy for 11*N cycles on a clean RAM, then a one-cycle done pulse.
// Backpressure: none; start is ignored unless idle, rst aborts a test immediately.
module ram_bist
   import ram_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [2:0]            fail_elem,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   state_t                  state, state_n;
   elem_t                   elem, elem_n;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    last;
   logic                    load, load_down, step;
   logic                    mismatch;
   logic                    cap_fail, set_pass, clr_result;
   logic                    we_n;
   logic [DATA_WIDTH-1:0]   din_n;
   logic [DATA_WIDTH-1:0]   exp_val;

   ram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_down (load_down),
      .step      (step),
      .down      (EL_DOWN[elem]),
      .addr      (addr),
      .last      (last)
   );

   assign ram_addr = addr;
   assign exp_val  = {DATA_WIDTH{EL_RD_ONES[elem]}};
   assign mismatch = (ram_dout != exp_val);

   // Next-state, element sequencing and address-counter control.
   always_comb begin
      state_n    = state;
      elem_n     = elem;
      load       = 1'b0;
      load_down  = 1'b0;
      step       = 1'b0;
      cap_fail   = 1'b0;
      set_pass   = 1'b0;
      clr_result = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n    = S_WR;
               elem_n     = M0;
               load       = 1'b1;
               load_down  = EL_DOWN[M0];
               clr_result = 1'b1;
            end
         end
         S_WR: begin
            if (last) begin
               state_n   = S_RD;
               elem_n    = M1;
               load      = 1'b1;
               load_down = EL_DOWN[M1];
            end else begin
               step = 1'b1;
            end
         end
         S_RD: begin
            state_n = S_CMP;
         end
         S_CMP: begin
            if (mismatch) begin
               state_n  = S_DONE;
               cap_fail = 1'b1;
            end else if (last) begin
               if (elem == M5) begin
                  state_n  = S_DONE;
                  set_pass = 1'b1;
               end else begin
                  state_n   = S_RD;
                  elem_n    = elem_t'(elem + 3'd1);
                  load      = 1'b1;
                  load_down = EL_DOWN[elem_n];
               end
            end else begin
               state_n = S_RD;
               step    = 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // The write of a read-then-write step is committed when entering CMP so that
   // ram_we stays a clean register output; a mismatch sends the FSM to DONE,
   // which forces ram_we low from the following cycle on.
   assign we_n  = (state_n == S_WR) || ((state_n == S_CMP) && EL_WRITES[elem_n]);
   assign din_n = we_n ? {DATA_WIDTH{EL_WR_ONES[elem_n]}} : '0;

   // State and registered RAM-port / status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         elem    <= M0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ram_we  <= 1'b0;
         ram_din <= '0;
      end else begin
         state   <= state_n;
         elem    <= elem_n;
         busy    <= (state_n == S_WR) || (state_n == S_RD) || (state_n == S_CMP);
         done    <= (state_n == S_DONE);
         ram_we  <= we_n;
         ram_din <= din_n;
      end
   end

   // Result registers: cleared on an accepted start, first failure wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
         fail_elem <= '0;
      end else if (clr_result) begin
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
         fail_elem <= '0;
      end else if (cap_fail) begin
         fail_addr <= addr;
         fail_data <= ram_dout;
         fail_elem <= elem;
      end else if (set_pass) begin
         pass <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist: RAM model with an injectable stuck-at bit,
// per-cycle comparison of the RAM port against a March C- operation list.
// Randomized fault locations, start glitches and inter-run gaps.
module tb_ram_bist;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int N    = 1 << AW;
   localparam int ONES = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, pass, ram_we;
   logic [AW-1:0] fail_addr, ram_addr;
   logic [DW-1:0] fail_data, ram_din, ram_dout;
   logic [2:0]    fail_elem;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .fail_elem (fail_elem),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   // ---------------- RAM model with one stuck-at bit ----------------
   logic [DW-1:0] mem [N];
   logic [DW-1:0] rd_f;
   bit            f_en  = 1'b0;
   int            f_addr = 0;
   int            f_bit  = 0;
   bit            f_val  = 1'b0;

   always_comb begin
      rd_f = mem[ram_addr];
      if (f_en && (int'(ram_addr) == f_addr)) rd_f[f_bit] = f_val;
   end

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= rd_f;
   end

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit we;
      bit chk_we;
      bit chk_addr;
      int addr;
      int din;
   } op_t;

   op_t q[$];
   int  mm [N];
   bit  m_pass;
   int  m_fail_elem, m_fail_addr, m_fail_data;
   bit  prev_pass = 1'b0;

   task automatic push_op(input bit we, input bit cw, input bit ca, input int a, input int d);
      op_t o;
      o.we = we; o.chk_we = cw; o.chk_addr = ca; o.addr = a; o.din = d;
      q.push_back(o);
   endtask

   // Walks March C- abstractly over an int array; the stuck bit is applied on read.
   task automatic build_model(input bit faulty, input int fa, input int fb, input bit fv);
      bit stop;
      q.delete();
      m_pass = 1'b1; m_fail_elem = 0; m_fail_addr = 0; m_fail_data = 0;
      stop = 1'b0;
      for (int a = 0; a < N; a++) begin
         mm[a] = 0;
         push_op(1'b1, 1'b1, 1'b1, a, 0);
      end
      for (int e = 1; e <= 5 && !stop; e++) begin
         bit down;
         int rv, wv;
         down = (e >= 3);
         rv   = (e == 2 || e == 4) ? ONES : 0;
         wv   = (e == 1 || e == 3) ? ONES : 0;
         for (int k = 0; k < N && !stop; k++) begin
            int a, got;
            a   = down ? (N - 1 - k) : k;
            got = mm[a];
            if (faulty && a == fa) got = fv ? (got | (1 << fb)) : (got & ~(1 << fb));
            push_op(1'b0, 1'b1, 1'b1, a, 0);
            if (got != rv) begin
               m_pass = 1'b0; m_fail_elem = e; m_fail_addr = a; m_fail_data = got;
               push_op(1'b0, 1'b0, 1'b0, a, 0);
               stop = 1'b1;
            end else if (e < 5) begin
               mm[a] = wv;
               push_op(1'b1, 1'b1, 1'b1, a, wv);
            end else begin
               push_op(1'b0, 1'b1, 1'b0, a, 0);
            end
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_pass"},  pass, 0);
      chk({tag, "_faddr"}, fail_addr, 0);
      chk({tag, "_fdata"}, fail_data, 0);
      chk({tag, "_felem"}, fail_elem, 0);
      chk({tag, "_we"},    ram_we, 0);
      chk({tag, "_addr"},  ram_addr, 0);
      chk({tag, "_din"},   ram_din, 0);
   endtask

   // One test: start, per-cycle port check, end-of-test result check.
   task automatic do_run(input bit faulty, input int fa, input int fb, input bit fv,
                         input bit extra, input int rst_at, input bit sid, input bit hold_chk);
      int c;
      bit ended;
      op_t o;
      build_model(faulty, fa, fb, fv);
      f_en = faulty; f_addr = fa; f_bit = fb; f_val = fv;
      @(posedge clk); #1 start = 1'b1;
      if (hold_chk) begin
         @(negedge clk);
         chk("pass_hold", pass, prev_pass);
      end
      @(posedge clk); #1 start = 1'b0;
      ended = 1'b0;
      c = 0;
      while (!ended && c < 11 * N + 20) begin
         @(negedge clk);
         if (!busy) begin
            ended = 1'b1;
         end else begin
            if (c == 0) begin
               chk("pass_cleared", pass, 0);
               chk("felem_cleared", fail_elem, 0);
            end
            if (c < q.size()) begin
               o = q[c];
               if (o.chk_we)   chk("we", ram_we, o.we);
               if (o.chk_addr) chk("addr", ram_addr, o.addr);
               if (o.we)       chk("din", ram_din, o.din);
            end else begin
               chk("busy_overrun", c, q.size());
            end
            chk("done_in_busy", done, 0);
            start = extra && (c == 20 || c == 100);
            if (c == rst_at) begin
               rst = 1'b1; start = 1'b1;
               @(posedge clk); #1 rst = 1'b0; start = 1'b0;
               @(negedge clk);
               chk_all_zero("rst_mid");
               @(negedge clk);
               chk("rst_wins_busy", busy, 0);
               prev_pass = 1'b0;
               return;
            end
            c++;
         end
      end
      start = 1'b0;
      if (!ended) chk("done_timeout", 0, 1);
      chk("busy_cycles", c, q.size());
      chk("done", done, 1);
      chk("pass", pass, m_pass);
      chk("fail_elem", fail_elem, m_fail_elem);
      chk("fail_addr", fail_addr, m_fail_addr);
      chk("fail_data", fail_data, m_fail_data);
      chk("we_in_done", ram_we, 0);
      prev_pass = m_pass;
      if (sid) begin
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         chk("start_in_done_busy", busy, 0);
         chk("start_in_done_done", done, 0);
      end
   endtask

   task automatic idle_checks(input int n, input int fe, input int fa, input int fd);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_we", ram_we, 0);
         chk("idle_pass", pass, prev_pass);
         chk("idle_felem", fail_elem, fe);
         chk("idle_faddr", fail_addr, fa);
         chk("idle_fdata", fail_data, fd);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      // Clean run with start pulses at cycles 20 and 100.
      do_run(1'b0, 0, 0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      chk("clean_pass", pass, 1);
      idle_checks(3, 0, 0, 0);

      // Bit 3 of address 5 stuck at 1.
      do_run(1'b1, 5, 3, 1'b1, 1'b0, -1, 1'b0, 1'b0);
      chk("sa1_elem", fail_elem, 1);
      chk("sa1_addr", fail_addr, 5);
      chk("sa1_data", fail_data, 8'h08);
      idle_checks(3, 1, 5, 8'h08);

      // Bit 0 of address 10 stuck at 0.
      do_run(1'b1, 10, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      chk("sa0_elem", fail_elem, 2);
      chk("sa0_addr", fail_addr, 10);
      chk("sa0_data", fail_data, 8'hFE);
      idle_checks(2, 2, 10, 8'hFE);

      // Reset in the middle of a test, then a full clean run.
      do_run(1'b0, 0, 0, 1'b0, 1'b0, 40, 1'b0, 1'b0);
      do_run(1'b0, 0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

      // Back-to-back: start in the cycle after done, then start in the done cycle.
      do_run(1'b0, 0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
      do_run(1'b0, 0, 0, 1'b0, 1'b0, -1, 1'b1, 1'b0);
      idle_checks(2, 0, 0, 0);

      // Randomized faults and start glitches.
      for (int r = 0; r < 10; r++) begin
         bit rf, rv, rx;
         int ra, rb;
         rf = 1'($urandom_range(0, 1));
         ra = int'($urandom_range(0, N - 1));
         rb = int'($urandom_range(0, DW - 1));
         rv = 1'($urandom_range(0, 1));
         rx = 1'($urandom_range(0, 1));
         do_run(rf, ra, rb, rv, rx, -1, 1'b0, 1'b0);
         idle_checks(int'($urandom_range(1, 3)), m_fail_elem, m_fail_addr, m_fail_data);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test controller sitting directly upstream of `single_port_ram`. It owns the RAM's `we`/`addr`/`din` port and consumes its `dout`, running a March C- sequence over the full address space. It reports pass/fail together with the first failing address, data and march element. In mission mode a mux (outside this block) selects between functional traffic and this controller; that mux is controlled by `busy`.

## Interface
Parameters:
- ADDR_WIDTH, 4, RAM address width; depth N = 2**ADDR_WIDTH
- DATA_WIDTH, 8, RAM word width

Ports:
- clk  input  1  rising-edge clock, shared with RAM
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a test; ignored while busy
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at test end
- pass  output  1  result of last completed test; held until next accepted start
- fail_addr  output  ADDR_WIDTH  address of first mismatch
- fail_data  output  DATA_WIDTH  dout value read at first mismatch
- fail_elem  output  3  march element index (0–5) of first mismatch
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_din  output  DATA_WIDTH  RAM write data
- ram_dout  input  DATA_WIDTH  RAM read data; valid the cycle after ram_addr is presented with ram_we=0

## Operation
- March elements, with Z = all-zeros and O = all-ones:
  - M0: up, write Z
  - M1: up, read Z then write O
  - M2: up, read O then write Z
  - M3: down, read Z then write O
  - M4: down, read O then write Z
  - M5: down, read Z
- "Up" runs addresses 0→N-1; "down" runs N-1→0.
- FSM states:
  - IDLE: wait for start.
  - WR: M0 only; one address per cycle.
  - RD: issue read; ram_we=0, ram_addr=current.
  - CMP: compare ram_dout against the expected value. On match in M1–M4, issue the write at the same address with ram_we=1 this cycle. On match in M5, no write.
  - DONE: pulse done for one cycle, then return to IDLE.
- FSM transitions:
  - IDLE→WR on start.
  - WR→RD after address N-1, with the element set to M1.
  - RD→CMP always.
  - CMP→RD at the next address within an element.
  - CMP→RD at the first address of the next element when an element ends.
  - CMP→DONE after M5 reaches address 0, or immediately on a mismatch.
- First mismatch: capture fail_addr, fail_data and fail_elem, clear pass, and abort with no further RAM writes.
- All-match completion: pass=1; fail_* fields are held at 0.
- Address counter wrap:
  - up element ends at N-1;
  - down element ends at 0;
  - the counter reloads to 0 (up) or N-1 (down) at element change; no modular overrun is used.

## Timing
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_data=0, fail_elem=0, ram_we=0, ram_addr=0, ram_din=0; FSM in IDLE.
- All outputs are registered.
- start sampled high in IDLE → busy=1 and the first M0 write (addr 0) on the next cycle.
- Latency for a clean run: N cycles (M0) + 5×2N cycles (M1–M5) = 11N cycles of busy. This is 176 cycles at N=16, followed by the done pulse.
- done is asserted in the cycle busy falls. pass and fail_* are valid in the done cycle and stay stable afterwards.
- start while busy: ignored. start in the done cycle: ignored.
- rst mid-test: on the next edge all outputs return to reset values, ram_we drops, and the test is abandoned. RAM contents are undefined afterwards.
- start and rst high in the same cycle: rst wins.

## Structure
- Shared package holds:
  - FSM state enum (IDLE, WR, RD, CMP, DONE);
  - march element codes M0–M5;
  - per-element constants for direction, expected read value and write value.
- One sub-module, `ram_bist_addr_gen`: an up/down address counter with load-to-start and a terminal-count flag per direction.
- Top-level FSM, compare logic and result registers live in `ram_bist`.

## Test plan
- Clean RAM, N=16, start at cycle 0:
  - busy stays high 176 cycles;
  - done pulses once;
  - pass=1, fail_addr=0, fail_data=0, fail_elem=0.
- Bit 3 of addr 5 stuck at 1:
  - first mismatch is in M1;
  - fail_elem=1, fail_addr=5, fail_data=8'h08, pass=0;
  - no ram_we after the mismatch cycle.
- Bit 0 of addr 10 stuck at 0:
  - fail_elem=2, fail_addr=10, fail_data=8'hFE, pass=0.
- rst asserted at cycle 40 of a test:
  - next cycle all outputs are 0 and FSM is IDLE;
  - a following start runs a full clean 176-cycle pass.
- start pulsed again at cycles 20 and 100 of a running test: ignored, and the total busy duration is unchanged.
- Back-to-back runs: start in the cycle after done → a second clean run. pass stays 1 from the first done until that start is accepted, then clears, and is set again at the second done.
